hazard_forward_unit: RTL and testbench

Parametrised successor to the pipeline's two-operand forwarding logic: it generates forward-mux selects for NUM_SRC operands and adds sequential load-use stall control and a pipeline freeze for a non-ready data memory. It sits in the ID/EXE boundary. It drives the operand muxes in EXE plus the stall/freeze enables of the IF/ID and pipeline registers. It replaces the separate forwarding and hazard-detection blocks.

---
 rtl/hazard_forward_unit_if.sv | 65 ++++++
 rtl/hazard_forward_unit.sv | 158 +++++++++++++++
 tb/tb_hazard_forward_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_if.sv
// rtl/hazard_forward_unit_if.sv - operand/hazard signal bundle between the ID/EXE pipeline and hazard_forward_unit
//
// Parameters: REG_W (register address width), NUM_SRC (source operands examined)
// master modport : pipeline side, drives operand/producer info, receives selects and stall/freeze
// slave modport  : hazard_forward_unit side
// Signals:
//   forwardEn              forwarding mode enable
//   srcValid / src         per-operand valid and register number (operand i at [i*REG_W +: REG_W])
//   exeWbEn / exeMemRead   EXE-stage instruction writes back / is a load
//   exeDest                EXE-stage destination
//   wbEnMem / destMem      MEM-stage writeback enable and destination
//   wbEnWb / destWb        WB-stage writeback enable and destination
//   memReady               data memory ready (low = access in progress)
//   flush                  taken branch, kill younger instructions
//   selSrc                 per-operand forward select at [2i +: 2]: 00 regfile, 01 MEM, 10 WB
//   stall                  hold PC and IF/ID, bubble into EXE
//   freeze                 hold all pipeline registers
//   stallCount             saturating stall-cycle counter (only with STALL_STATS_EN)
interface hazard_forward_unit_if #(
   parameter int REG_W   = 4,
   parameter int NUM_SRC = 2
);
   logic                     forwardEn;
   logic [NUM_SRC-1:0]       srcValid;
   logic [NUM_SRC*REG_W-1:0] src;
   logic                     exeWbEn;
   logic                     exeMemRead;
   logic [REG_W-1:0]         exeDest;
   logic                     wbEnMem;
   logic                     wbEnWb;
   logic [REG_W-1:0]         destMem;
   logic [REG_W-1:0]         destWb;
   logic                     memReady;
   logic                     flush;
   logic [2*NUM_SRC-1:0]     selSrc;
   logic                     stall;
   logic                     freeze;
`ifdef STALL_STATS_EN
   logic [15:0]              stallCount;

   modport master (
      output forwardEn, srcValid, src, exeWbEn, exeMemRead, exeDest,
             wbEnMem, wbEnWb, destMem, destWb, memReady, flush,
      input  selSrc, stall, freeze, stallCount
   );

   modport slave (
      input  forwardEn, srcValid, src, exeWbEn, exeMemRead, exeDest,
             wbEnMem, wbEnWb, destMem, destWb, memReady, flush,
      output selSrc, stall, freeze, stallCount
   );
`else
   modport master (
      output forwardEn, srcValid, src, exeWbEn, exeMemRead, exeDest,
             wbEnMem, wbEnWb, destMem, destWb, memReady, flush,
      input  selSrc, stall, freeze
   );

   modport slave (
      input  forwardEn, srcValid, src, exeWbEn, exeMemRead, exeDest,
             wbEnMem, wbEnWb, destMem, destWb, memReady, flush,
      output selSrc, stall, freeze
   );
`endif
endinterface

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - forwarding select, load-use stall FSM and memory freeze for the ID/EXE boundary
//
// Parameters: REG_W (register address width), NUM_SRC (operands, 1..4), LOAD_LAT (stall cycles per load-use, 1..7)
// Ports:
//   clk   rising-edge clock
//   rstN  asynchronous active-low reset
//   bus   hazard_forward_unit_if.slave (operand/producer info in; selSrc/stall/freeze out)
// Optional feature: define STALL_STATS_EN to add the 16-bit saturating bus.stallCount output.
module hazard_forward_unit #(
   parameter int REG_W    = 4,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rstN,
   hazard_forward_unit_if.slave  bus
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_BUBBLE = 1'b1;

   // Detection cycle is the first stall cycle, so the counter covers the rest.
   localparam logic [2:0] CNT_INIT     = 3'(LOAD_LAT - 1);
   localparam bit         MULTI_BUBBLE = (LOAD_LAT > 1);

   logic [0:0] state_q, state_d;
   logic [2:0] cnt_q, cnt_d;

   logic [NUM_SRC-1:0]   hit_exe;
   logic [NUM_SRC-1:0]   hit_mem;
   logic [NUM_SRC-1:0]   hit_wb;
   logic [2*NUM_SRC-1:0] sel_src;
   logic                 haz_load;
   logic                 haz_raw;
   logic                 haz;
   logic                 freeze_int;
   logic                 flush_take;
   logic                 stall_int;

   // Per-operand address compares; invalid operands never match.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         logic [REG_W-1:0] src_op;
         assign src_op      = bus.src[gi*REG_W +: REG_W];
         assign hit_exe[gi] = bus.srcValid[gi] & (src_op == bus.exeDest);
         assign hit_mem[gi] = bus.srcValid[gi] & (src_op == bus.destMem);
         assign hit_wb[gi]  = bus.srcValid[gi] & (src_op == bus.destWb);
      end
   endgenerate

   // With forwarding only a load in EXE is unresolvable; without it any
   // in-flight producer in EXE or MEM blocks the consumer.
   assign haz_load   = bus.exeWbEn & bus.exeMemRead & (|hit_exe);
   assign haz_raw    = (bus.exeWbEn & (|hit_exe)) | (bus.wbEnMem & (|hit_mem));
   assign haz        = bus.forwardEn ? haz_load : haz_raw;

   assign freeze_int = ~bus.memReady;
   // A frozen pipeline cannot act on flush; the branch unit re-presents it.
   assign flush_take = bus.flush & ~freeze_int;

   // Forward selects, MEM wins over WB because it holds the younger value.
   always_comb begin
      sel_src = '0;
      if (bus.forwardEn) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.wbEnMem & hit_mem[i]) begin
               sel_src[2*i +: 2] = 2'b01;
            end else if (bus.wbEnWb & hit_wb[i]) begin
               sel_src[2*i +: 2] = 2'b10;
            end
         end
      end
   end

   always_comb begin
      stall_int = 1'b0;
      if (flush_take) begin
         stall_int = 1'b0;
      end else if (state_q == ST_BUBBLE) begin
         stall_int = 1'b1;
      end else begin
         stall_int = haz;
      end
   end

   // Only load-use hazards under forwarding need the counted sequence;
   // raw hazards clear on their own as the producer moves down the pipe.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!freeze_int) begin
         if (bus.flush) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (haz && bus.forwardEn && MULTI_BUBBLE) begin
                     state_d = ST_BUBBLE;
                     cnt_d   = CNT_INIT;
                  end
               end
               ST_BUBBLE: begin
                  if (cnt_q <= 3'd1) begin
                     state_d = ST_IDLE;
                     cnt_d   = 3'd0;
                  end else begin
                     cnt_d = cnt_q - 3'd1;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  cnt_d   = 3'd0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are gated by reset so a mid-sequence reset drops stall at once
   // and nothing combinational leaks out while the core is held.
   assign bus.selSrc = rstN ? sel_src : '0;
   assign bus.stall  = rstN & stall_int;
   assign bus.freeze = rstN & freeze_int;

`ifdef STALL_STATS_EN
   logic [15:0] stall_count_q, stall_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall_int && !freeze_int && (stall_count_q != 16'hFFFF)) begin
         stall_count_d = stall_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         stall_count_q <= 16'd0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign bus.stallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed self-checking bench for hazard_forward_unit (LOAD_LAT=3)
module tb_hazard_forward_unit;

   logic clk;
   logic rstN;
   int   n_vec;
   int   n_err;

   hazard_forward_unit_if #(.REG_W(4), .NUM_SRC(2)) bus ();

   hazard_forward_unit #(.REG_W(4), .NUM_SRC(2), .LOAD_LAT(3)) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clr();
      bus.forwardEn  = 1'b1;
      bus.srcValid   = 2'b00;
      bus.src        = 8'h00;
      bus.exeWbEn    = 1'b0;
      bus.exeMemRead = 1'b0;
      bus.exeDest    = 4'd0;
      bus.wbEnMem    = 1'b0;
      bus.wbEnWb     = 1'b0;
      bus.destMem    = 4'd0;
      bus.destWb     = 4'd0;
      bus.memReady   = 1'b1;
      bus.flush      = 1'b0;
   endtask

   task automatic load_use();
      bus.forwardEn  = 1'b1;
      bus.exeWbEn    = 1'b1;
      bus.exeMemRead = 1'b1;
      bus.exeDest    = 4'd5;
      bus.src        = {4'd5, 4'd2};
      bus.srcValid   = 2'b11;
   endtask

   task automatic clear_exe();
      bus.exeWbEn    = 1'b0;
      bus.exeMemRead = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      clr();
      rstN = 1'b0;

      // Reset holds every output low even with hazards and matches present.
      bus.src      = {4'd3, 4'd3};
      bus.srcValid = 2'b11;
      bus.wbEnMem  = 1'b1;
      bus.destMem  = 4'd3;
      bus.exeWbEn  = 1'b1;
      bus.exeMemRead = 1'b1;
      bus.exeDest  = 4'd3;
      bus.memReady = 1'b0;
      #3;
      chk("rst_sel", 16'(bus.selSrc), 16'h0);
      chk("rst_stall", 16'(bus.stall), 16'h0);
      chk("rst_freeze", 16'(bus.freeze), 16'h0);
`ifdef STALL_STATS_EN
      chk("rst_count", bus.stallCount, 16'h0);
`endif
      clr();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      tick();

      // Forward selects: double match goes to MEM on both operands.
      bus.src = {4'd3, 4'd3}; bus.srcValid = 2'b11;
      bus.wbEnMem = 1'b1; bus.destMem = 4'd3;
      bus.wbEnWb  = 1'b1; bus.destWb  = 4'd3;
      settle();
      chk("fwd_dbl_sel", 16'(bus.selSrc), 16'h5);
      chk("fwd_dbl_stall", 16'(bus.stall), 16'h0);
      bus.destMem = 4'd4;
      settle();
      chk("fwd_wb_only", 16'(bus.selSrc), 16'hA);
      bus.src = {4'd4, 4'd3};
      settle();
      chk("fwd_mixed", 16'(bus.selSrc), 16'h6);
      bus.srcValid = 2'b01;
      settle();
      chk("fwd_invalid", 16'(bus.selSrc), 16'h2);
      bus.srcValid = 2'b11; bus.forwardEn = 1'b0;
      settle();
      chk("fwd_disabled", 16'(bus.selSrc), 16'h0);
      clr();
      bus.src = {4'd9, 4'd0}; bus.srcValid = 2'b11;
      bus.wbEnMem = 1'b1; bus.destMem = 4'd0;
      settle();
      chk("fwd_reg0", 16'(bus.selSrc), 16'h1);
      clr();
      tick();

      // Load-use with LOAD_LAT=3: three stall cycles.
      load_use();
      settle();
      chk("lu_det", 16'(bus.stall), 16'h1);
      tick(); clear_exe(); settle();
      chk("lu_b1", 16'(bus.stall), 16'h1);
      tick(); settle();
      chk("lu_b2", 16'(bus.stall), 16'h1);
      tick(); settle();
      chk("lu_end", 16'(bus.stall), 16'h0);

      // Invalid consumer operand never raises stall.
      load_use(); bus.srcValid = 2'b01;
      settle();
      chk("lu_inv0", 16'(bus.stall), 16'h0);
      tick(); settle();
      chk("lu_inv1", 16'(bus.stall), 16'h0);
      clr();
      tick();

      // Freeze for two cycles in BUBBLE: five stall cycles in total.
      load_use(); settle();
      chk("fz_det", 16'(bus.stall), 16'h1);
      tick(); clear_exe(); bus.memReady = 1'b0; settle();
      chk("fz_f1_freeze", 16'(bus.freeze), 16'h1);
      chk("fz_f1_stall", 16'(bus.stall), 16'h1);
      tick(); settle();
      chk("fz_f2_freeze", 16'(bus.freeze), 16'h1);
      chk("fz_f2_stall", 16'(bus.stall), 16'h1);
      tick(); bus.memReady = 1'b1; settle();
      chk("fz_b1_freeze", 16'(bus.freeze), 16'h0);
      chk("fz_b1_stall", 16'(bus.stall), 16'h1);
      tick(); settle();
      chk("fz_b2_stall", 16'(bus.stall), 16'h1);
      tick(); settle();
      chk("fz_end", 16'(bus.stall), 16'h0);

      // Flush in the second stall cycle kills the sequence.
      load_use(); settle();
      tick(); clear_exe(); bus.flush = 1'b1; settle();
      chk("fl_same", 16'(bus.stall), 16'h0);
      tick(); bus.flush = 1'b0; settle();
      chk("fl_idle", 16'(bus.stall), 16'h0);

      // Flush while frozen is ignored.
      load_use(); settle();
      tick(); clear_exe(); bus.flush = 1'b1; bus.memReady = 1'b0; settle();
      chk("flz_same", 16'(bus.stall), 16'h1);
      tick(); bus.flush = 1'b0; bus.memReady = 1'b1; settle();
      chk("flz_b1", 16'(bus.stall), 16'h1);
      tick(); settle();
      chk("flz_b2", 16'(bus.stall), 16'h1);
      tick(); settle();
      chk("flz_end", 16'(bus.stall), 16'h0);

      // Back-to-back load-use: new hazard on the return to IDLE, no gap.
      load_use(); settle();
      tick(); clear_exe(); settle();
      chk("bb_b1", 16'(bus.stall), 16'h1);
      tick(); load_use(); settle();
      chk("bb_b2", 16'(bus.stall), 16'h1);
      tick(); settle();
      chk("bb_det2", 16'(bus.stall), 16'h1);
      tick(); clear_exe(); settle();
      chk("bb2_b1", 16'(bus.stall), 16'h1);
      tick(); settle();
      chk("bb2_b2", 16'(bus.stall), 16'h1);
      tick(); settle();
      chk("bb_end", 16'(bus.stall), 16'h0);
      clr();

      // Non-forwarding hazards are purely combinational.
      bus.forwardEn = 1'b0;
      bus.wbEnMem = 1'b1; bus.destMem = 4'd7;
      bus.src = {4'd1, 4'd7}; bus.srcValid = 2'b01;
      settle();
      chk("nf_mem_stall", 16'(bus.stall), 16'h1);
      chk("nf_mem_sel", 16'(bus.selSrc), 16'h0);
      bus.destMem = 4'd6;
      settle();
      chk("nf_clear", 16'(bus.stall), 16'h0);
      bus.wbEnMem = 1'b0;
      bus.exeWbEn = 1'b1; bus.exeDest = 4'd7;
      settle();
      chk("nf_exe_stall", 16'(bus.stall), 16'h1);
      tick(); bus.exeWbEn = 1'b0; settle();
      chk("nf_no_bubble", 16'(bus.stall), 16'h0);
      clr();
      tick();

      // Asynchronous reset in BUBBLE drops stall without a clock edge.
      load_use(); settle();
      tick(); clear_exe(); settle();
      chk("ar_bubble", 16'(bus.stall), 16'h1);
      #1;
      rstN = 1'b0;
      #1;
      chk("ar_drop", 16'(bus.stall), 16'h0);
      @(negedge clk);
      rstN = 1'b1;
      tick(); settle();
      chk("ar_idle", 16'(bus.stall), 16'h0);

`ifdef STALL_STATS_EN
      // Forced raw hazard for 70000 cycles saturates the counter.
      bus.forwardEn = 1'b0;
      bus.wbEnMem = 1'b1; bus.destMem = 4'd7;
      bus.src = {4'd0, 4'd7}; bus.srcValid = 2'b01;
      repeat (70000) @(posedge clk);
      #2;
      chk("cnt_sat", bus.stallCount, 16'hFFFF);
      rstN = 1'b0;
      #1;
      chk("cnt_rst", bus.stallCount, 16'h0);
      @(negedge clk);
      rstN = 1'b1;
      clr();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
